// File: rtl/sc_lane_shift_ctrl.sv
// Purpose : paces single-cycle lane-rotate commands (and a one-cycle load
//           strobe) for a downstream shift register, from a prescaled base tick.
// Latency : all outputs registered; the first rotate command lands
//           PRESCALE*(speed+1) cycles after the load cycle.
// Backpressure: none downstream; pause freezes the pacing counters in place.
// Ports   : CLOCK_50 / RESET_InLow       clock, async active-low reset
//           start_InLow                  level, low = (re)load lane and run
//           pause_In                     high = freeze motion (HOLD)
//           direction_In                 0 = toward MSB, 1 = toward LSB
//           speed_InBUS                  rotate period in base ticks, minus 1
//           load_OutLow                  low for exactly the LOAD cycle
//           shiftselection_OutBUS        00 hold, 01 toward MSB, 10 toward LSB
//           data_OutBUS                  lane pattern to load
//           running_Out                  high while in RUN
module sc_lane_shift_ctrl #(
  parameter int LANESHIFT_DATAWIDTH = 8,
  parameter logic [LANESHIFT_DATAWIDTH-1:0] LANESHIFT_INITPATTERN = 8'b00110011,
  parameter int LANESHIFT_PRESCALE = 1250000
) (
  input  logic                           SC_LANE_SHIFT_CTRL_CLOCK_50,
  input  logic                           SC_LANE_SHIFT_CTRL_RESET_InLow,
  input  logic                           SC_LANE_SHIFT_CTRL_start_InLow,
  input  logic                           SC_LANE_SHIFT_CTRL_pause_In,
  input  logic                           SC_LANE_SHIFT_CTRL_direction_In,
  input  logic [3:0]                     SC_LANE_SHIFT_CTRL_speed_InBUS,
  output logic                           SC_LANE_SHIFT_CTRL_load_OutLow,
  output logic [1:0]                     SC_LANE_SHIFT_CTRL_shiftselection_OutBUS,
  output logic [LANESHIFT_DATAWIDTH-1:0] SC_LANE_SHIFT_CTRL_data_OutBUS,
  output logic                           SC_LANE_SHIFT_CTRL_running_Out
);

  localparam int BaseWidth = $clog2(LANESHIFT_PRESCALE);
  localparam logic [BaseWidth-1:0] BaseReload = BaseWidth'(LANESHIFT_PRESCALE - 1);
  localparam logic [BaseWidth-1:0] BaseOne    = BaseWidth'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } laneStateT;

  laneStateT            laneState;
  logic [BaseWidth-1:0] baseCnt;
  logic [3:0]           stepCnt;
  logic                 loadLow;
  logic                 runningReg;
  logic [1:0]           shiftSel;
  logic                 goLoad;

  // Start wins over everything except an in-progress LOAD, which always
  // hands over to RUN; holding start low therefore alternates LOAD/RUN.
  assign goLoad = !SC_LANE_SHIFT_CTRL_start_InLow && (laneState != LOAD);

  always_ff @(posedge SC_LANE_SHIFT_CTRL_CLOCK_50 or negedge SC_LANE_SHIFT_CTRL_RESET_InLow) begin
    if (!SC_LANE_SHIFT_CTRL_RESET_InLow) begin
      laneState  <= IDLE;
      loadLow    <= 1'b1;
      shiftSel   <= 2'b00;
      runningReg <= 1'b0;
      baseCnt    <= BaseReload;
      stepCnt    <= 4'd0;
    end else begin
      shiftSel <= 2'b00;
      if (goLoad) begin
        laneState  <= LOAD;
        loadLow    <= 1'b0;
        runningReg <= 1'b0;
        baseCnt    <= BaseReload;
        stepCnt    <= 4'd0;
      end else begin
        loadLow <= 1'b1;
        case (laneState)
          IDLE: begin
            laneState  <= IDLE;
            runningReg <= 1'b0;
          end
          LOAD: begin
            laneState  <= RUN;
            runningReg <= 1'b1;
          end
          RUN, HOLD: begin
            if (SC_LANE_SHIFT_CTRL_pause_In) begin
              // Counters stay frozen; a pulse due now is simply deferred.
              laneState  <= HOLD;
              runningReg <= 1'b0;
            end else begin
              // The cycle that leaves HOLD already counts, so a pause costs
              // exactly as many cycles as it is held.
              laneState  <= RUN;
              runningReg <= 1'b1;
              baseCnt    <= (baseCnt == '0) ? BaseReload : (baseCnt - BaseOne);
              // Base tick is taken on the edge where baseCnt reaches zero so
              // the registered pulse is visible in that zero cycle; this is
              // what keeps the first pulse at PRESCALE*(speed+1) after LOAD.
              if (baseCnt == BaseOne) begin
                // >= rather than == so a speed cut below stepCnt fires at
                // once instead of wrapping the 4-bit step counter.
                if (stepCnt >= SC_LANE_SHIFT_CTRL_speed_InBUS) begin
                  stepCnt  <= 4'd0;
                  shiftSel <= SC_LANE_SHIFT_CTRL_direction_In ? 2'b10 : 2'b01;
                end else begin
                  stepCnt <= stepCnt + 4'd1;
                end
              end
            end
          end
          default: begin
            laneState  <= IDLE;
            runningReg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SC_LANE_SHIFT_CTRL_load_OutLow           = loadLow;
  assign SC_LANE_SHIFT_CTRL_shiftselection_OutBUS = shiftSel;
  assign SC_LANE_SHIFT_CTRL_running_Out           = runningReg;
  // The load pattern is fixed; it is only captured downstream while load is low.
  assign SC_LANE_SHIFT_CTRL_data_OutBUS           = LANESHIFT_INITPATTERN;

endmodule
